// File: rtl/if_stage_if.sv
// Bus bundle between the fetch stage, the decode stage and the instruction SRAM.
interface if_stage_if;
  logic        ds_allowin;
  logic [32:0] br_bus;
  logic        fs_to_ds_valid;
  logic [64:0] fs_to_ds_bus;
  logic        inst_sram_en;
  logic        inst_sram_we;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata;

  modport master (
    input  ds_allowin, br_bus, inst_sram_rdata,
    output fs_to_ds_valid, fs_to_ds_bus, inst_sram_en, inst_sram_we, inst_sram_addr,
           inst_sram_wdata
  );

  modport slave (
    output ds_allowin, br_bus, inst_sram_rdata,
    input  fs_to_ds_valid, fs_to_ds_bus, inst_sram_en, inst_sram_we, inst_sram_addr,
           inst_sram_wdata
  );
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, next-PC select, SRAM request, stall hold buffer, branch squash.
// Define IF_ADEF_CHECK_EN to flag misaligned fetch addresses as ADEF instead of fetching them.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h1c000000
) (
  input logic  clk,
  input logic  reset,
  if_stage_if.master bus
);

  logic        br_taken;
  logic [31:0] br_target;
  logic        to_fs_valid;
  logic        fs_ready_go;
  logic        fs_allowin;
  logic [31:0] nextpc;
  logic        nextpc_adef;
  logic        fs_excp_adef;
  logic [31:0] fs_inst;

  logic        fs_valid_q;
  logic [31:0] fs_pc_q;
  logic        inst_buf_valid_q;
  logic [31:0] inst_buf_q;
  logic        br_pending_q;
  logic [31:0] br_target_q;

  assign br_taken  = bus.br_bus[32];
  assign br_target = bus.br_bus[31:0];

  always_comb begin
    to_fs_valid = ~reset;
    fs_ready_go = 1'b1;
    fs_allowin  = ~fs_valid_q | (fs_ready_go & bus.ds_allowin);
    nextpc      = br_taken ? br_target : br_pending_q ? br_target_q : fs_pc_q + 32'd4;
  end

`ifdef IF_ADEF_CHECK_EN
  logic fs_excp_adef_q;

  assign nextpc_adef  = |nextpc[1:0];
  assign fs_excp_adef = fs_excp_adef_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      fs_excp_adef_q <= 1'b0;
    end else if (fs_allowin) begin
      fs_excp_adef_q <= nextpc_adef;
    end
  end
`else
  assign nextpc_adef  = 1'b0;
  assign fs_excp_adef = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      fs_valid_q       <= 1'b0;
      fs_pc_q          <= RESET_PC - 32'd4;
      inst_buf_valid_q <= 1'b0;
      br_pending_q     <= 1'b0;
    end else begin
      if (fs_allowin) begin
        fs_valid_q <= to_fs_valid;
        fs_pc_q    <= nextpc;
      end else if (br_taken) begin
        fs_valid_q <= 1'b0;
      end
      // A redirect that cannot be requested now is replayed on the next free cycle.
      if (br_taken & ~fs_allowin) begin
        br_pending_q <= 1'b1;
      end else if (fs_allowin) begin
        br_pending_q <= 1'b0;
      end
      if (br_taken | (fs_valid_q & bus.ds_allowin)) begin
        inst_buf_valid_q <= 1'b0;
      end else if (fs_valid_q & ~bus.ds_allowin & ~inst_buf_valid_q) begin
        inst_buf_valid_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (br_taken) begin
      br_target_q <= br_target;
    end
    // SRAM data is only valid for one cycle, so keep it while ID stalls.
    if (fs_valid_q & ~bus.ds_allowin & ~inst_buf_valid_q) begin
      inst_buf_q <= bus.inst_sram_rdata;
    end
  end

  always_comb begin
    fs_inst = inst_buf_valid_q ? inst_buf_q : bus.inst_sram_rdata;
    if (fs_excp_adef) begin
      fs_inst = 32'h0;
    end
    bus.fs_to_ds_valid  = fs_valid_q & ~br_taken & ~reset;
    bus.fs_to_ds_bus    = {fs_excp_adef, fs_inst, fs_pc_q};
    bus.inst_sram_en    = to_fs_valid & fs_allowin & ~nextpc_adef;
    bus.inst_sram_we    = 1'b0;
    bus.inst_sram_addr  = nextpc;
    bus.inst_sram_wdata = 32'h0;
  end

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed vectors, a PC-level reference model and literal pins.
module tb_if_stage;
  localparam logic [31:0] RP      = 32'h1c000000;
  localparam logic [31:0] GARBAGE = 32'hbad0bad0;

  logic clk = 1'b0;
  logic reset = 1'b1;
  if_stage_if bus ();

  if_stage #(.RESET_PC(RP)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.master)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'h5a5aa5a5;
  endfunction

  // Instruction SRAM: data one cycle after an accepted request, garbage otherwise.
  always @(posedge clk) begin
    bus.inst_sram_rdata <= bus.inst_sram_en ? word(bus.inst_sram_addr) : GARBAGE;
  end

  int n_chk = 0;
  int n_pass = 0;

  // Model: which PC sits in IF and which PC the fetcher will ask for next.
  logic        m_v = 1'b0, m_pend = 1'b0, m_mis = 1'b0;
  logic [31:0] m_pc = '0, m_last = RP - 32'd4, m_tgt = '0;
  logic        n_v, n_pend, n_mis;
  logic [31:0] n_pc, n_last, n_tgt;

  task automatic chk(input string name, input logic [64:0] got, input logic [64:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  task automatic drive(input logic rst, input logic alw, input logic br, input logic [31:0] tgt);
    logic        e_allow, e_mis, e_valid, e_en;
    logic [31:0] e_addr;
    reset = rst;
    bus.ds_allowin = alw;
    bus.br_bus = {br, tgt};
    @(negedge clk);
    e_allow = !m_v || alw;
    e_addr  = br ? tgt : m_pend ? m_tgt : m_last + 32'd4;
`ifdef IF_ADEF_CHECK_EN
    e_mis = e_addr[1:0] != 2'b00;
`else
    e_mis = 1'b0;
`endif
    e_en    = !rst && e_allow && !e_mis;
    e_valid = !rst && m_v && !br;
    chk("valid", bus.fs_to_ds_valid, e_valid);
    chk("sram_en", bus.inst_sram_en, e_en);
    chk("sram_we_wdata", {bus.inst_sram_we, bus.inst_sram_wdata}, 0);
    if (!rst) chk("sram_addr", bus.inst_sram_addr, e_addr);
    if (e_valid) begin
      chk("fs_pc", bus.fs_to_ds_bus[31:0], m_pc);
      chk("fs_inst", bus.fs_to_ds_bus[63:32], m_mis ? 32'h0 : word(m_pc));
      chk("fs_adef", bus.fs_to_ds_bus[64], m_mis);
    end
    {n_v, n_pc, n_last, n_pend, n_tgt, n_mis} = {m_v, m_pc, m_last, m_pend, m_tgt, m_mis};
    if (rst) begin
      n_v = 1'b0; n_last = RP - 32'd4; n_pend = 1'b0; n_mis = 1'b0;
    end else if (e_allow) begin
      n_v = 1'b1; n_pc = e_addr; n_last = e_addr; n_pend = 1'b0; n_mis = e_mis;
    end else if (br) begin
      n_v = 1'b0; n_pend = 1'b1; n_tgt = tgt;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    {m_v, m_pc, m_last, m_pend, m_tgt, m_mis} = {n_v, n_pc, n_last, n_pend, n_tgt, n_mis};
    #1;
  endtask

  initial begin
    bus.ds_allowin = 1'b1;
    bus.br_bus = '0;
    bus.inst_sram_rdata = GARBAGE;
    drive(1, 1, 0, 0); tick();
    drive(1, 1, 0, 0); tick();
    // Straight-line fetch
    drive(0, 1, 0, 0); chk("lit_first_addr", bus.inst_sram_addr, RP); tick();
    drive(0, 1, 0, 0); chk("lit_pc0", bus.fs_to_ds_bus[31:0], RP);
    chk("lit_addr1", bus.inst_sram_addr, 32'h1c000004); tick();
    drive(0, 1, 0, 0); chk("lit_pc1", bus.fs_to_ds_bus[31:0], 32'h1c000004); tick();
    // ID stall for three cycles holding 1c000008
    drive(0, 0, 0, 0); chk("lit_stall_en", bus.inst_sram_en, 0); tick();
    drive(0, 0, 0, 0); tick();
    drive(0, 0, 0, 0); chk("lit_stall_inst", bus.fs_to_ds_bus[63:32], word(32'h1c000008)); tick();
    drive(0, 1, 0, 0); chk("lit_release_pc", bus.fs_to_ds_bus[31:0], 32'h1c000008); tick();
    // Redirect with ID accepting
    drive(0, 1, 1, 32'h1c000100); chk("lit_br_addr", bus.inst_sram_addr, 32'h1c000100);
    chk("lit_br_squash", bus.fs_to_ds_valid, 0); tick();
    drive(0, 1, 0, 0); chk("lit_br_pc", bus.fs_to_ds_bus[31:0], 32'h1c000100); tick();
    // Redirect while ID stalls
    drive(0, 0, 0, 0); tick();
    drive(0, 0, 1, 32'h1c000200); tick();
    drive(0, 0, 0, 0); chk("lit_pend_addr", bus.inst_sram_addr, 32'h1c000200);
    chk("lit_pend_en", bus.inst_sram_en, 1); tick();
    drive(0, 1, 0, 0); chk("lit_pend_pc", bus.fs_to_ds_bus[31:0], 32'h1c000200); tick();
    drive(0, 1, 0, 0); tick();
    // Reset in the middle of a stall with the hold buffer full
    drive(0, 0, 0, 0); tick();
    drive(0, 0, 0, 0); tick();
    drive(1, 0, 0, 0); chk("lit_rst_valid", bus.fs_to_ds_valid, 0); tick();
    drive(0, 1, 0, 0); chk("lit_restart_addr", bus.inst_sram_addr, RP); tick();
    drive(0, 1, 0, 0); chk("lit_restart_inst", bus.fs_to_ds_bus[63:32], word(RP)); tick();
    // 32-bit PC wrap
    drive(0, 1, 1, 32'hfffffffc); tick();
    drive(0, 1, 0, 0); chk("lit_wrap_addr", bus.inst_sram_addr, 32'h0); tick();
    // Mixed stall pattern checked by the model alone
    for (int i = 0; i < 16; i++) begin
      drive(0, (i % 3) != 1, i == 9, 32'h1c000400); tick();
    end
`ifdef IF_ADEF_CHECK_EN
    drive(0, 1, 1, 32'h1c000102); chk("lit_adef_en", bus.inst_sram_en, 0); tick();
    drive(0, 1, 1, 32'h1c000300);
    chk("lit_adef_bus", bus.fs_to_ds_bus, {1'b1, 32'h0, 32'h1c000102}); tick();
    drive(0, 1, 0, 0); tick();
`endif
    drive(0, 1, 0, 0); tick();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
Instruction-fetch stage for the pipelined LoongArch 20-instruction CPU. It sits directly upstream of the decode (ID) stage.
- Owns the PC and pre-IF next-PC selection.
- Drives the synchronous inst SRAM.
- Holds the fetched instruction when ID stalls.
- Hands {inst, pc} to ID through a valid/allowin handshake.
- Accepts branch redirects from ID and squashes the wrong-path fetch.

Parameters:
RESET_PC, 32'h1c000000, address of first instruction fetched after reset.

Ports:
clk  in  1  system clock; all state updates on posedge.
reset  in  1  synchronous, active-high reset.
ds_allowin  in  1  ID can accept an instruction this cycle.
br_bus  in  33  {br_taken[32], br_target[31:0]}. br_taken is a one-cycle pulse, already qualified by ID valid.
fs_to_ds_valid  out  1  fs_to_ds_bus holds a valid instruction.
fs_to_ds_bus  out  65  {fs_excp_adef[64], fs_inst[63:32], fs_pc[31:0]}.
inst_sram_en  out  1  read request strobe.
inst_sram_we  out  1  constant 0.
inst_sram_addr  out  32  request address (nextpc).
inst_sram_wdata  out  32  constant 0.
inst_sram_rdata  in  32  read data, valid the cycle after an accepted request.

Behaviour:
Reset and clocking:
- Single clock clk; reset is synchronous and active-high.
- While reset=1 on a posedge: fs_valid<=0, fs_pc<=RESET_PC-4, inst_buf_valid<=0, br_pending<=0.
- Outputs during reset: fs_to_ds_valid=0, inst_sram_en=0.
- First request after reset deassertion: inst_sram_addr=RESET_PC.

Pre-IF:
- to_fs_valid = ~reset.
- nextpc = br_taken ? br_target : br_pending ? br_target_r : fs_pc+4.
- PC arithmetic is 32-bit modulo; wrap from 32'hfffffffc to 0 is silent.
- inst_sram_en = to_fs_valid & fs_allowin. inst_sram_addr = nextpc regardless of en.

IF handshake:
- fs_ready_go = 1.
- fs_allowin = ~fs_valid | (fs_ready_go & ds_allowin).
- fs_to_ds_valid = fs_valid & ~br_taken.
- On posedge with fs_allowin: fs_valid<=to_fs_valid, fs_pc<=nextpc.
- Fetch-to-ID latency is 1 cycle when ID never stalls: one instruction per cycle.

Instruction hold buffer:
- fs_inst = inst_buf_valid ? inst_buf : inst_sram_rdata.
- Capture: when fs_valid & ~ds_allowin & ~inst_buf_valid, inst_buf<=inst_sram_rdata and inst_buf_valid<=1.
- Clear inst_buf_valid on (fs_valid & ds_allowin), br_taken, or reset.
- Multi-cycle ID stalls must present the same fs_inst on every cycle.

Branch redirect:
- When br_taken=1, the instruction currently in IF is wrong-path:
  - it is never presented valid (fs_to_ds_valid=0 that cycle);
  - it is never forwarded later.
- br_taken & fs_allowin: request br_target in the same cycle; fs_pc<=br_target.
- br_taken & ~fs_allowin:
  - fs_valid<=0, inst_buf_valid<=0;
  - br_pending<=1, br_target_r<=br_target.
  - The next cycle (fs_allowin=1 because fs_valid=0) requests br_target_r; br_pending clears on that request.
- br_taken while br_pending=1: the new target overwrites br_target_r.

Optional Feature:
Macro IF_ADEF_CHECK_EN.
- Defined:
  - nextpc[1:0]!=0 suppresses inst_sram_en for that request.
  - Registers fs_excp_adef<=1 with the PC.
  - fs_inst is forced to 32'h0 while fs_excp_adef=1.
  - The instruction is still passed to ID valid, so ID/WB raise ADEF.
- Not defined: fs_excp_adef is constant 0 and no alignment check exists.

Test Plan:
1. Reset then run with ds_allowin=1 and SRAM returning pc-tagged data → addr sequence 1c000000, 1c000004, 1c000008. fs_to_ds_valid rises 1 cycle after the first request; fs_pc/fs_inst pairs match.
2. ds_allowin=0 for 3 cycles while IF holds pc 1c000008; SRAM rdata changed to garbage → inst_sram_en=0 during stall; fs_inst stays the 1c000008 word; released in order with no skip or duplicate.
3. br_taken pulse with target 1c000100 while ds_allowin=1 → inst_sram_addr=1c000100 that cycle; IF instruction squashed (fs_to_ds_valid=0); next valid fs_pc=1c000100.
4. br_taken (target 1c000200) while ds_allowin=0 and fs_valid=1 → next cycle request 1c000200; wrong-path instruction never appears valid; br_pending cleared.
5. reset asserted mid-stall with inst_buf_valid=1 → next cycle fs_to_ds_valid=0; after release, fetch restarts at 1c000000 with a fresh instruction, not the buffered one.
6. (IF_ADEF_CHECK_EN) br_target 1c000102 → inst_sram_en=0 for that request; fs_to_ds_bus[64]=1, fs_inst=0, fs_pc=1c000102.
